// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and parity helper for the UART word link.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StPar   = 3'd3,
    StStop  = 3'd4
  } uart_state_e;

  // Parity bit that makes the frame's total ones count even (odd=0) or odd (odd=1).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every BAUD_DIV clocks.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 163
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(BAUD_DIV - 1));
  assign o_tick = w_wrap;

  // Divider counter running 0..BAUD_DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_word_link.sv
// Parametrised UART link moving WORD_BYTES-byte words over 8-bit frames in both directions.
module uart_word_link
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = 163,
  parameter int unsigned WORD_BYTES   = 4,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  output logic                    tx,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [8*WORD_BYTES-1:0] rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    overrun,
  output logic                    timeout
);

  localparam int unsigned WordW   = 8 * WORD_BYTES;
  localparam int unsigned BcntW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned ToTicks = TIMEOUT_BITS * OVERSAMPLE;
  localparam int unsigned IdleW   = $clog2(ToTicks + 1);

  logic w_tick;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .o_tick(w_tick)
  );

  // ---------------------------------------------------------------- RX path
  logic             r_rx_s1, r_rx_s2;
  logic             w_rx;
  uart_state_e      r_rx_state, w_rx_next;
  logic [3:0]       r_rx_tick;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_sh;
  logic             r_rx_par;
  logic [BcntW-1:0] r_rx_bcnt;
  logic [WordW-1:0] r_rx_word, w_rx_word_new, r_rx_data;
  logic             r_rx_valid;
  logic [IdleW-1:0] r_idle;
  logic             r_frame_err, r_parity_err, r_overrun, r_timeout;
  logic             w_rx_bit_end, w_stop_done, w_frame_bad, w_par_bad, w_byte_ok;
  logic             w_word_done, w_start_det, w_to_fire, w_blocked;

  assign w_rx = r_rx_s2;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx_bit_end = w_tick && (r_rx_tick == 4'(OVERSAMPLE - 1));
  assign w_start_det  = w_tick && (r_rx_state == StIdle) && !w_rx;
  assign w_stop_done  = w_rx_bit_end && (r_rx_state == StStop);
  assign w_frame_bad  = !w_rx;
  assign w_par_bad    = PARITY_EN && (parity_bit(r_rx_sh, PARITY_ODD) != r_rx_par);
  assign w_byte_ok    = w_stop_done && !w_frame_bad && !w_par_bad;
  assign w_word_done  = w_byte_ok && (r_rx_bcnt == BcntW'(WORD_BYTES - 1));
  assign w_blocked    = r_rx_valid && !rx_ready;
  assign w_to_fire    = w_tick && (r_rx_state == StIdle) && w_rx && (r_rx_bcnt != '0) &&
                        (r_idle == IdleW'(ToTicks - 1));

  // RX state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rx_state <= StIdle;
    else        r_rx_state <= w_rx_next;
  end

  // RX next-state logic; every transition happens on a tick.
  always_comb begin
    w_rx_next = r_rx_state;
    if (w_tick) begin
      unique case (r_rx_state)
        StIdle:  if (!w_rx) w_rx_next = StStart;
        StStart: if (r_rx_tick == 4'(MID_SAMPLE)) w_rx_next = w_rx ? StIdle : StData;
        StData:  if (w_rx_bit_end && r_rx_bit == 3'(DATA_BITS - 1))
                   w_rx_next = PARITY_EN ? StPar : StStop;
        StPar:   if (w_rx_bit_end) w_rx_next = StStop;
        StStop:  if (w_rx_bit_end) w_rx_next = StIdle;
        default: w_rx_next = StIdle;
      endcase
    end
  end

  // Current partial word with the just-received byte dropped into its slot.
  always_comb begin
    w_rx_word_new = r_rx_word;
    for (int k = 0; k < int'(WORD_BYTES); k++) begin
      if (r_rx_bcnt == BcntW'(k)) w_rx_word_new[8*k +: 8] = r_rx_sh;
    end
  end

  // RX datapath: bit sampling, word assembly, error pulses and idle timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_tick    <= '0;
      r_rx_bit     <= '0;
      r_rx_sh      <= '0;
      r_rx_par     <= 1'b0;
      r_rx_bcnt    <= '0;
      r_rx_word    <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_idle       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;

      // Tick counter restarts on every state change and wraps within DATA.
      if (w_tick) begin
        if (w_rx_next != r_rx_state)  r_rx_tick <= '0;
        else if (r_rx_state != StIdle) r_rx_tick <= r_rx_tick + 4'd1;
      end

      if (w_start_det) r_rx_bit <= '0;
      if (w_rx_bit_end && r_rx_state == StData) begin
        r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
      if (w_rx_bit_end && r_rx_state == StPar) r_rx_par <= w_rx;

      if (w_stop_done) begin
        r_frame_err  <= w_frame_bad;
        r_parity_err <= w_par_bad;
        if (!w_byte_ok) begin
          r_rx_bcnt <= '0;
        end else if (w_word_done) begin
          r_rx_bcnt <= '0;
          if (w_blocked) r_overrun <= 1'b1;
          else           r_rx_data <= w_rx_word_new;
        end else begin
          r_rx_word <= w_rx_word_new;
          r_rx_bcnt <= r_rx_bcnt + BcntW'(1);
        end
      end

      if (w_to_fire) begin
        r_rx_bcnt <= '0;
        r_timeout <= 1'b1;
      end

      // Idle counter only runs while a partial word waits in IDLE.
      if (r_rx_state != StIdle || r_rx_bcnt == '0 || w_start_det || w_to_fire) begin
        r_idle <= '0;
      end else if (w_tick) begin
        r_idle <= r_idle + IdleW'(1);
      end

      // A consume in the same cycle as a completion frees the slot for the new word.
      if (w_word_done && !w_blocked) r_rx_valid <= 1'b1;
      else if (rx_ready)             r_rx_valid <= 1'b0;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;

  // ---------------------------------------------------------------- TX path
  uart_state_e      r_tx_state, w_tx_next;
  logic             r_tx_pend;
  logic [3:0]       r_tx_tick;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_sh;
  logic             r_tx_par;
  logic [BcntW-1:0] r_tx_bcnt;
  logic [WordW-1:0] r_tx_word;
  logic             w_tx_bit_end, w_tx_last_byte, w_tx_accept, w_tx_load;

  assign w_tx_bit_end   = w_tick && (r_tx_tick == 4'(OVERSAMPLE - 1));
  assign w_tx_last_byte = (r_tx_bcnt == BcntW'(WORD_BYTES - 1));
  assign w_tx_accept    = tx_valid && tx_ready;
  assign w_tx_load      = (r_tx_state == StIdle && w_tick && r_tx_pend) ||
                          (r_tx_state == StStop && w_tx_bit_end && !w_tx_last_byte);

  // TX state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_tx_state <= StIdle;
    else        r_tx_state <= w_tx_next;
  end

  // TX next-state logic; bytes chain STOP -> START with no idle gap.
  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      StIdle:  if (w_tick && r_tx_pend) w_tx_next = StStart;
      StStart: if (w_tx_bit_end) w_tx_next = StData;
      StData:  if (w_tx_bit_end && r_tx_bit == 3'(DATA_BITS - 1))
                 w_tx_next = PARITY_EN ? StPar : StStop;
      StPar:   if (w_tx_bit_end) w_tx_next = StStop;
      StStop:  if (w_tx_bit_end) w_tx_next = w_tx_last_byte ? StIdle : StStart;
      default: w_tx_next = StIdle;
    endcase
  end

  // TX outputs decoded from state so reset forces the line high at once.
  always_comb begin
    tx       = 1'b1;
    tx_ready = (r_tx_state == StIdle) && !r_tx_pend;
    unique case (r_tx_state)
      StStart: tx = 1'b0;
      StData:  tx = r_tx_sh[0];
      StPar:   tx = r_tx_par;
      default: tx = 1'b1;
    endcase
  end

  // TX datapath: word latch, per-byte load and bit shifting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_pend <= 1'b0;
      r_tx_tick <= '0;
      r_tx_bit  <= '0;
      r_tx_sh   <= '0;
      r_tx_par  <= 1'b0;
      r_tx_bcnt <= '0;
      r_tx_word <= '0;
    end else begin
      if (w_tick) begin
        if (w_tx_next != r_tx_state)  r_tx_tick <= '0;
        else if (r_tx_state != StIdle) r_tx_tick <= r_tx_tick + 4'd1;
      end

      if (w_tx_accept) begin
        r_tx_word <= tx_data;
        r_tx_pend <= 1'b1;
      end else if (w_tx_load) begin
        r_tx_sh   <= r_tx_word[7:0];
        r_tx_par  <= parity_bit(r_tx_word[7:0], PARITY_ODD);
        r_tx_word <= r_tx_word >> 8;
        r_tx_bit  <= '0;
        r_tx_pend <= 1'b0;
        r_tx_bcnt <= (r_tx_state == StIdle) ? '0 : r_tx_bcnt + BcntW'(1);
      end else if (w_tx_bit_end && r_tx_state == StData) begin
        r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
        r_tx_bit <= r_tx_bit + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_link.sv
// Directed self-checking bench for uart_word_link (BAUD_DIV=4, 64 clk per bit).
module tb_uart_word_link;

  logic        clk = 1'b0;
  logic        reset;
  logic        lb;
  logic        drv_rx_a, drv_rx_p;
  logic        rx_a, tx_a, tx_p;
  logic [31:0] tx_data_a;
  logic        tx_valid_a, tx_ready_a, tx_ready_p;
  logic [31:0] rx_data_a, rx_data_p;
  logic        rx_valid_a, rx_valid_p, rx_ready_a;
  logic        frame_err_a, parity_err_a, overrun_a, timeout_a;
  logic        frame_err_p, parity_err_p, overrun_p, timeout_p;

  int checks = 0;
  int failures = 0;
  int ferr_a = 0, perr_a = 0, ovr_a = 0, to_a = 0;
  int ferr_p = 0, perr_p = 0, ovr_p = 0, to_p = 0;

  always #5 clk = ~clk;

  assign rx_a = lb ? tx_a : drv_rx_a;

  uart_word_link #(
    .BAUD_DIV(4), .WORD_BYTES(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .TIMEOUT_BITS(32)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx_a), .tx(tx_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .frame_err(frame_err_a), .parity_err(parity_err_a), .overrun(overrun_a),
    .timeout(timeout_a)
  );

  uart_word_link #(
    .BAUD_DIV(4), .WORD_BYTES(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .TIMEOUT_BITS(32)
  ) dut_p (
    .clk(clk), .reset(reset), .rx(drv_rx_p), .tx(tx_p),
    .tx_data(32'h0), .tx_valid(1'b0), .tx_ready(tx_ready_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(1'b0),
    .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p),
    .timeout(timeout_p)
  );

  // Pulse counters for both instances.
  always @(posedge clk) begin
    if (frame_err_a)  ferr_a <= ferr_a + 1;
    if (parity_err_a) perr_a <= perr_a + 1;
    if (overrun_a)    ovr_a  <= ovr_a + 1;
    if (timeout_a)    to_a   <= to_a + 1;
    if (frame_err_p)  ferr_p <= ferr_p + 1;
    if (parity_err_p) perr_p <= perr_p + 1;
    if (overrun_p)    ovr_p  <= ovr_p + 1;
    if (timeout_p)    to_p   <= to_p + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit to_p, input logic v);
    if (to_p) drv_rx_p = v;
    else      drv_rx_a = v;
  endtask

  task automatic send_byte(input bit to_p, input logic [7:0] b, input bit stop_ok,
                           input bit has_par, input bit par);
    set_line(to_p, 1'b0);
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(to_p, b[i]);
      repeat (64) @(negedge clk);
    end
    if (has_par) begin
      set_line(to_p, par);
      repeat (64) @(negedge clk);
    end
    if (stop_ok) begin
      set_line(to_p, 1'b1);
      repeat (64) @(negedge clk);
    end else begin
      // Low only across the mid-bit sample, then back to idle.
      set_line(to_p, 1'b0);
      repeat (46) @(negedge clk);
      set_line(to_p, 1'b1);
      repeat (82) @(negedge clk);
    end
  endtask

  task automatic send_word(input bit to_p, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      send_byte(to_p, b, 1'b1, to_p, ^b);
    end
  endtask

  task automatic consume_a();
    rx_ready_a = 1'b1;
    @(posedge clk);
    #1;
    chk("rx_valid_drop_after_ready", 64'(rx_valid_a), 64'(0));
    rx_ready_a = 1'b0;
    @(negedge clk);
  endtask

  logic [7:0] caught [4];
  int lat;

  // Decode four frames from the tx pin, sampling mid-bit.
  task automatic grab_tx_bytes();
    for (int k = 0; k < 4; k++) begin
      int n;
      logic [7:0] b;
      n = 0;
      while (tx_a !== 1'b0 && n < 5000) begin
        @(negedge clk);
        n++;
      end
      chk("tx_start_seen", 64'(n < 5000), 64'(1));
      repeat (32) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (64) @(negedge clk);
        b[i] = tx_a;
      end
      repeat (64) @(negedge clk);
      chk("tx_stop_bit", 64'(tx_a), 64'(1));
      caught[k] = b;
    end
  endtask

  initial begin
    int f0, o0, t0, p0;
    reset = 1'b0; lb = 1'b0; drv_rx_a = 1'b1; drv_rx_p = 1'b1;
    rx_ready_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = '0;
    repeat (5) @(negedge clk);
    chk("tx_in_reset", 64'(tx_a), 64'(1));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", 64'(tx_a), 64'(1));
    chk("reset_tx_ready", 64'(tx_ready_a), 64'(1));
    chk("reset_rx_valid", 64'(rx_valid_a), 64'(0));
    chk("reset_rx_data", 64'(rx_data_a), 64'(0));
    chk("reset_p_tx", 64'({tx_p, tx_ready_p, rx_valid_p}), 64'(3'b110));

    // 1: loopback word, tx byte order and tx_ready latency.
    lb = 1'b1;
    tx_data_a = 32'hDEADBEEF;
    tx_valid_a = 1'b1;
    @(posedge clk);
    #1;
    tx_valid_a = 1'b0;
    tx_data_a = 32'h0;
    chk("tx_ready_low_after_accept", 64'(tx_ready_a), 64'(0));
    fork
      grab_tx_bytes();
      begin
        bit seen;
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 4000) begin
          @(posedge clk);
          lat++;
          #1;
          seen = tx_ready_a;
        end
      end
    join
    chk("tx_byte0", 64'(caught[0]), 64'(8'hEF));
    chk("tx_byte1", 64'(caught[1]), 64'(8'hBE));
    chk("tx_byte2", 64'(caught[2]), 64'(8'hAD));
    chk("tx_byte3", 64'(caught[3]), 64'(8'hDE));
    chk("tx_ready_latency_in_window", 64'(lat >= 2556 && lat <= 2568), 64'(1));
    @(negedge clk);
    chk("loop_rx_valid", 64'(rx_valid_a), 64'(1));
    chk("loop_rx_data", 64'(rx_data_a), 64'(32'hDEADBEEF));
    lb = 1'b0;
    consume_a();

    // 2: overrun keeps the held word.
    send_word(1'b0, 32'h44332211);
    chk("ovr_first_valid", 64'(rx_valid_a), 64'(1));
    chk("ovr_first_data", 64'(rx_data_a), 64'(32'h44332211));
    o0 = ovr_a;
    send_word(1'b0, 32'h88776655);
    chk("ovr_pulse_count", 64'(ovr_a - o0), 64'(1));
    chk("ovr_data_kept", 64'(rx_data_a), 64'(32'h44332211));
    chk("ovr_still_valid", 64'(rx_valid_a), 64'(1));
    consume_a();

    // 3: bad stop bit as second byte clears the partial word.
    f0 = ferr_a;
    send_byte(1'b0, 8'h99, 1'b1, 1'b0, 1'b0);
    send_byte(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (64) @(negedge clk);
    chk("frame_err_pulse", 64'(ferr_a - f0), 64'(1));
    chk("frame_err_no_valid", 64'(rx_valid_a), 64'(0));
    send_word(1'b0, 32'h04030201);
    chk("after_ferr_valid", 64'(rx_valid_a), 64'(1));
    chk("after_ferr_data", 64'(rx_data_a), 64'(32'h04030201));
    consume_a();

    // 4: even parity; 0x07 needs parity bit 1.
    p0 = perr_p;
    send_byte(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
    chk("parity_err_pulse", 64'(perr_p - p0), 64'(1));
    chk("parity_err_no_valid", 64'(rx_valid_p), 64'(0));
    send_word(1'b1, 32'h07070707);
    chk("parity_ok_no_new_err", 64'(perr_p - p0), 64'(1));
    chk("parity_ok_valid", 64'(rx_valid_p), 64'(1));
    chk("parity_ok_data", 64'(rx_data_p), 64'(32'h07070707));

    // 5: partial word times out after 32 idle bit-times.
    t0 = to_a;
    send_byte(1'b0, 8'h12, 1'b1, 1'b0, 1'b0);
    send_byte(1'b0, 8'h34, 1'b1, 1'b0, 1'b0);
    repeat (1950) @(negedge clk);
    chk("timeout_not_early", 64'(to_a - t0), 64'(0));
    repeat (200) @(negedge clk);
    chk("timeout_pulse", 64'(to_a - t0), 64'(1));
    chk("timeout_no_valid", 64'(rx_valid_a), 64'(0));
    send_word(1'b0, 32'hDDCCBBAA);
    chk("after_timeout_data", 64'(rx_data_a), 64'(32'hDDCCBBAA));
    consume_a();

    // 6a: short low glitch is not a frame.
    f0 = ferr_a;
    drv_rx_a = 1'b0;
    repeat (12) @(negedge clk);
    drv_rx_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_valid", 64'(rx_valid_a), 64'(0));
    chk("glitch_no_ferr", 64'(ferr_a - f0), 64'(0));
    send_word(1'b0, 32'h40302010);
    chk("after_glitch_data", 64'(rx_data_a), 64'(32'h40302010));
    consume_a();

    // 6b: reset in the middle of a tx byte (bit 3 of 0xA5 is low).
    tx_data_a = 32'hA5A5A5A5;
    tx_valid_a = 1'b1;
    @(posedge clk);
    #1;
    tx_valid_a = 1'b0;
    repeat (300) @(negedge clk);
    chk("tx_busy_mid_frame", 64'(tx_ready_a), 64'(0));
    chk("tx_low_mid_frame", 64'(tx_a), 64'(0));
    reset = 1'b0;
    #1;
    chk("reset_mid_tx_line", 64'(tx_a), 64'(1));
    chk("reset_mid_tx_ready", 64'(tx_ready_a), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    chk("no_resume_after_reset", 64'(tx_a), 64'(1));
    chk("p_side_stray_pulses", 64'(ovr_p + to_p + ferr_p), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_link.md
Name: uart_word_link

Overview:
Parametrised UART link that replaces the fixed 8N1, 32-bit word UART top. It contains:
- one shared 16x-oversampling baud generator;
- an RX path that assembles WORD_BYTES bytes into one word, with parity, framing and inter-byte timeout checking;
- a TX path that serialises one word as WORD_BYTES frames.

It sits between the board serial pins and the MIPS debug/loader logic, and exposes valid/ready handshakes on both word interfaces.

Parameters:
BAUD_DIV, 163, clk cycles per oversample tick (50 MHz / 19200 / 16); legal range ≥2.
WORD_BYTES, 4, bytes per word; legal range 1..8.
PARITY_EN, 0, 1 = insert/check a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
TIMEOUT_BITS, 32, bit-times of RX idle after which a partial word is discarded.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output
tx_data  in  8*WORD_BYTES  word to send; byte 0 = bits [7:0]
tx_valid  in  1  tx_data is valid
tx_ready  out  1  block can accept a word
rx_data  out  8*WORD_BYTES  received word
rx_valid  out  1  rx_data holds an unconsumed word
rx_ready  in  1  consumer takes rx_data
frame_err  out  1  one-cycle pulse: stop bit sampled as 0
parity_err  out  1  one-cycle pulse: parity mismatch
overrun  out  1  one-cycle pulse: word completed while rx_valid=1 and rx_ready=0
timeout  out  1  one-cycle pulse: partial word discarded

Behaviour:
- Reset (reset=0, asynchronous): tx=1, tx_ready=1, rx_valid=0, rx_data=0, all error pulses 0, byte counters 0, both FSMs in IDLE, baud counter 0. Asserting reset mid-frame aborts the frame immediately; tx returns to 1 with no partial stop bit.
- Baud tick:
  - Counter runs 0..BAUD_DIV-1.
  - tick=1 for one clk when the counter equals BAUD_DIV-1.
  - One bit time = 16 ticks.
- RX synchroniser: 2-flop, both flops reset to 1. Every RX decision uses the synchronised value.
- RX FSM, states IDLE → START → DATA → PAR → STOP → IDLE:
  - IDLE: on rx=0 at a tick, go to START and clear the tick counter.
  - START: at tick 7, if rx=1 it was a glitch, return to IDLE with nothing recorded; otherwise reset the tick counter.
  - DATA: sample every 16th tick, 8 bits, LSB first.
  - PAR: only entered when PARITY_EN=1.
  - STOP: sample at the 16th tick, then go to IDLE.
- RX frame errors:
  - Stop bit = 0: frame_err pulse; byte dropped; partial word cleared (byte count = 0).
  - Parity mismatch: parity_err pulse with the same discard and clear.
  - If both occur, both pulses fire in the same cycle.
- Word assembly:
  - Byte k lands in bits [8k+7:8k]; the first received byte is the LSB byte.
  - On the WORD_BYTES-th good byte, rx_data loads the word and rx_valid=1 the next clk.
  - rx_valid stays high until a clk with rx_ready=1.
- Overrun: a word completes while rx_valid=1 and rx_ready=0 → overrun pulse; the new word is dropped and rx_data is unchanged.
- Simultaneous consume and complete: rx_ready=1 and a word completes in the same clk → old word consumed, new word loaded, rx_valid stays 1, no overrun.
- Timeout:
  - Applies only when byte count > 0 and the RX FSM is in IDLE.
  - An idle counter counts ticks; at TIMEOUT_BITS*16 ticks, byte count goes to 0 and timeout pulses.
  - Any start bit clears the idle counter.
- TX handshake:
  - Transfer occurs when tx_valid=1 and tx_ready=1 on a rising clk edge.
  - tx_data is latched; tx_ready=0 from the next clk.
  - tx_data may change after acceptance.
- TX FSM, states IDLE → START → DATA → PAR → STOP:
  - The first start bit begins at the next tick after acceptance.
  - Each bit lasts 16 ticks.
  - Bytes are sent byte 0 first, back-to-back with no idle gap.
  - After the last stop bit completes, the FSM returns to IDLE and tx_ready=1 in the same clk.
- RX and TX are fully independent; loopback (tx tied to rx) is legal.

Decomposition:
- Shared package uart_pkg: OVERSAMPLE=16, MID_SAMPLE=7, DATA_BITS=8, FSM state encodings (IDLE/START/DATA/PAR/STOP), and a parity function (XOR-reduce, then XOR with PARITY_ODD).
- One sub-module, uart_baud_tick, parameterised by BAUD_DIV, driving tick.
- The RX and TX FSMs stay inside uart_word_link.

Test Plan:
All cases use BAUD_DIV=4 (bit time = 64 clk) and WORD_BYTES=4 unless stated.
1. Reset release → tx=1, tx_ready=1, rx_valid=0. Send 0xDEADBEEF on tx_data with tx looped to rx → tx line shows bytes EF, BE, AD, DE; rx_valid rises with rx_data=0xDEADBEEF. With PARITY_EN=0, tx_ready returns 4×10×64 clk (±1 tick) after acceptance.
2. Drive rx with the 4 frames 11, 22, 33, 44 while rx_ready=0, then a further 4-byte word → rx_data stays 0x44332211, one overrun pulse. Then rx_ready=1 → rx_valid drops next clk.
3. Drive rx with byte 0x55 whose stop bit = 0 as the 2nd byte of a word → frame_err pulse. Then send 4 clean bytes 01..04 → rx_data=0x04030201.
4. PARITY_EN=1, PARITY_ODD=0, byte 0x07 with parity bit 0 → parity_err pulse, no rx_valid. Same byte with parity bit 1 → accepted.
5. Send 2 bytes, then hold rx=1 for 32×64 clk → timeout pulse. Then send 4 bytes AA..DD → rx_data=0xDDCCBBAA.
6. rx low pulse of 3 tick-periods (glitch) → no frame is received. Reset asserted mid-TX byte → tx=1 immediately and tx_ready=1.
